// File: rtl/regfile_pkg.sv
// Shared constants for the register-file command sequencer: function-select codes,
// opcodes, register indices and the FSM state encoding.
package regfile_pkg;

  localparam logic [2:0] FUN_DEC   = 3'b000;
  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_CLEAR = 3'b011;

  localparam logic [2:0] OP_CLR    = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_DEC    = 3'd2;
  localparam logic [2:0] OP_MOV    = 3'd3;
  localparam logic [2:0] OP_SWAP   = 3'd4;
  localparam logic [2:0] OP_CLRALL = 3'd5;

  localparam logic [2:0] IDX_R1 = 3'd0;
  localparam logic [2:0] IDX_R2 = 3'd1;
  localparam logic [2:0] IDX_R3 = 3'd2;
  localparam logic [2:0] IDX_R4 = 3'd3;
  localparam logic [2:0] IDX_S1 = 3'd4;
  localparam logic [2:0] IDX_S2 = 3'd5;
  localparam logic [2:0] IDX_S3 = 3'd6;
  localparam logic [2:0] IDX_S4 = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WR1  = 3'd2,
    ST_WR2  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_CLRALL;
  endfunction

  // MOV and SWAP need a read phase to capture operands before writing.
  function automatic logic op_reads(input logic [2:0] op);
    return (op == OP_MOV) || (op == OP_SWAP);
  endfunction

endpackage

// File: rtl/regfile_sel_decode.sv
// Maps a 3-bit register index plus enable onto one-hot R (0-3) and S (4-7) enables.
module regfile_sel_decode
  import regfile_pkg::*;
(
  input  logic [2:0] idx,
  input  logic       en,
  output logic [3:0] reg_sel,
  output logic [3:0] scr_sel
);

  always_comb begin
    reg_sel = '0;
    scr_sel = '0;
    if (en) begin
      if (idx >= IDX_S1) scr_sel[idx[1:0]] = 1'b1;
      else               reg_sel[idx[1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Command sequencer driving an external register file through FunSel/RegSel/ScrSel.
//   state | meaning
//   IDLE  | ready for a command
//   READ  | read operands (MOV/SWAP) into tmpA/tmpB
//   WR1   | first write: dst (or all registers for CLRALL)
//   WR2   | SWAP only: write tmpB into src
//   DONE  | one-cycle done pulse, err for illegal opcodes
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_dst,
  input  logic [2:0]        cmd_src,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        FunSel,
  output logic [3:0]        RegSel,
  output logic [3:0]        ScrSel,
  output logic [2:0]        OutASel,
  output logic [2:0]        OutBSel,
  output logic [DATA_W-1:0] I,
  input  logic [DATA_W-1:0] OutA,
  input  logic [DATA_W-1:0] OutB
);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [2:0]          dst_q, dst_d;
  logic [2:0]          src_q, src_d;
  logic [DATA_W-1:0]   tmpa_q, tmpa_d;
  logic [DATA_W-1:0]   tmpb_q, tmpb_d;

  logic       dec_en;
  logic       all_en;
  logic [2:0] dec_idx;
  logic [3:0] dec_reg_sel;
  logic [3:0] dec_scr_sel;

  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      tmpa_q  <= '0;
      tmpb_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      tmpa_q  <= tmpa_d;
      tmpb_q  <= tmpb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    tmpa_d  = tmpa_q;
    tmpb_d  = tmpb_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          dst_d = cmd_dst;
          src_d = cmd_src;
          if (!op_legal(cmd_op))     state_d = ST_DONE;
          else if (op_reads(cmd_op)) state_d = ST_READ;
          else                       state_d = ST_WR1;
        end
      end
      ST_READ: begin
        tmpa_d  = OutA;
        tmpb_d  = OutB;
        state_d = ST_WR1;
      end
      ST_WR1:  state_d = (op_q == OP_SWAP) ? ST_WR2 : ST_DONE;
      ST_WR2:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state and latched command fields.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    FunSel    = FUN_LOAD;
    OutASel   = '0;
    OutBSel   = '0;
    I         = '0;
    dec_en    = 1'b0;
    all_en    = 1'b0;
    dec_idx   = dst_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_READ: begin
        OutASel = src_q;
        if (op_q == OP_SWAP) OutBSel = dst_q;
      end
      ST_WR1: begin
        dec_en = 1'b1;
        case (op_q)
          OP_CLR: FunSel = FUN_CLEAR;
          OP_INC: FunSel = FUN_INC;
          OP_DEC: FunSel = FUN_DEC;
          OP_MOV, OP_SWAP: begin
            FunSel = FUN_LOAD;
            I      = tmpa_q;
          end
          OP_CLRALL: begin
            dec_en = 1'b0;
            all_en = 1'b1;
            FunSel = FUN_CLEAR;
          end
          default: dec_en = 1'b0;
        endcase
      end
      ST_WR2: begin
        dec_en  = 1'b1;
        dec_idx = src_q;
        I       = tmpb_q;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = !op_legal(op_q);
      end
      default: ;
    endcase
  end

  regfile_sel_decode u_sel_decode (
    .idx     (dec_idx),
    .en      (dec_en),
    .reg_sel (dec_reg_sel),
    .scr_sel (dec_scr_sel)
  );

  assign RegSel = all_en ? 4'hF : dec_reg_sel;
  assign ScrSel = all_en ? 4'hF : dec_scr_sel;

endmodule
